// File: rtl/key_switch_pio_pkg.sv
// rtl/key_switch_pio_pkg.sv - shared register map and defaults for the key/switch input PIO
package key_switch_pio_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - per-pin 2-FF synchroniser, polarity fix-up and hold-time debouncer
module debounce_bit
  import key_switch_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  output logic synced,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  assign synced = sync_q ^ ACTIVE_LOW;
  assign stable = stable_q;

  // Sync stages reset to the idle pin level so synced reads "not pressed" out of
  // reset and a held pin has to travel the full synchroniser before counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= ACTIVE_LOW;
      sync_q   <= ACTIVE_LOW;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q <= pin_in;
      sync_q <= meta_q;
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LIMIT) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_switch_input_pio.sv
// rtl/key_switch_input_pio.sv - Avalon-MM key/switch input port with debounce, press latch and irq
module key_switch_input_pio
  import key_switch_pio_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] stable_d_q;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  word_t            rdata_q, rdata_d;
  logic             irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_in (pin_in[i]),
      .synced (synced[i]),
      .stable (stable[i])
    );
  end

  if (WIDTH < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^avs_writedata[31:WIDTH];
  end

  assign rise = stable & ~stable_d_q;

  // The W1C clear is applied before OR-ing in new presses so a same-cycle press survives.
  always_comb begin
    edge_d = edge_q;
    mask_d = mask_q;
    if (avs_write && avs_address == ADDR_EDGE) begin
      edge_d = edge_q & ~avs_writedata[WIDTH-1:0];
    end
    if (avs_write && avs_address == ADDR_MASK) begin
      mask_d = avs_writedata[WIDTH-1:0];
    end
    edge_d = edge_d | rise;
  end

  // Reads sample the registers before this cycle's write lands.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA: rdata_d = 32'(stable);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        default:   rdata_d = 32'(synced);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_q <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      stable_d_q <= stable;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_switch_input_pio.sv
// tb/tb_key_switch_input_pio.sv - directed self-checking bench for key_switch_input_pio
module tb_key_switch_input_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] pin_in = 16'h0000;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  key_switch_input_pio #(
    .WIDTH          (16),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pin_in       (pin_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered and left just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data     = avs_readdata;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] wdata);
    avs_address   = addr;
    avs_writedata = wdata;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] addr, input logic [31:0] wdata, output logic [31:0] data);
    avs_address   = addr;
    avs_writedata = wdata;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    avs_read  = 1'b0;
    data      = avs_readdata;
  endtask

  task automatic poll_data(input int bit_idx, output int found, output logic [31:0] last);
    int k;
    found = -1;
    k = 0;
    last = 32'd0;
    while (found < 0 && k < 20) begin
      k++;
      do_read(2'd0, last);
      if (last[bit_idx]) found = k;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          found;

    // 1: reset with all pins pressed
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    do_read(2'd0, d); chk("rst_data", d, 32'h0);
    do_read(2'd1, d); chk("rst_edge", d, 32'h0);
    do_read(2'd2, d); chk("rst_mask", d, 32'h0);
    do_read(2'd3, d); chk("rst_raw", d, 32'h0000_FFFF);
    chk("rst_irq2", {31'd0, irq}, 32'h0);
    pin_in = 16'hFFFF;
    tick(20);
    do_read(2'd0, d); chk("idle_data", d, 32'h0);
    do_read(2'd1, d); chk("idle_edge", d, 32'h0);
    do_read(2'd3, d); chk("idle_raw", d, 32'h0);

    // 2: 5-clock glitch on pin 0
    do_write(2'd2, 32'h1);
    pin_in = 16'hFFFE;
    tick(5);
    pin_in = 16'hFFFF;
    tick(15);
    do_read(2'd0, d); chk("glitch_data", d, 32'h0);
    do_read(2'd1, d); chk("glitch_edge", d, 32'h0);
    chk("glitch_irq", {31'd0, irq}, 32'h0);

    // 3: press pin 3
    do_write(2'd2, 32'h8);
    pin_in = 16'hFFF7;
    poll_data(3, found, d);
    chk("press_lat", 32'(found), 32'd11);
    chk("press_data", d, 32'h8);
    do_read(2'd1, d); chk("press_edge", d, 32'h8);
    chk("press_irq", {31'd0, irq}, 32'h1);

    // 4: W1C, release, then clear colliding with a new press
    do_write(2'd1, 32'h8);
    do_read(2'd1, d); chk("w1c_edge", d, 32'h0);
    chk("w1c_irq", {31'd0, irq}, 32'h0);
    pin_in = 16'hFFFF;
    tick(14);
    do_read(2'd0, d); chk("rel_data", d, 32'h0);
    do_read(2'd1, d); chk("rel_edge", d, 32'h0);
    chk("rel_irq", {31'd0, irq}, 32'h0);
    pin_in = 16'hFFF7;
    tick(10);
    do_write(2'd1, 32'h8);
    do_read(2'd1, d); chk("setwins_edge", d, 32'h8);

    // 5: mask width, read-only DATA, read+write same cycle
    do_write(2'd2, 32'hFFFF_FFFF);
    do_read(2'd2, d); chk("mask_width", d, 32'h0000_FFFF);
    do_write(2'd0, 32'h1234);
    do_read(2'd0, d); chk("data_ro", d, 32'h8);
    chk("mask_irq", {31'd0, irq}, 32'h1);
    do_rw(2'd2, 32'h0, d); chk("rw_old", d, 32'h0000_FFFF);
    do_read(2'd2, d); chk("rw_new", d, 32'h0);
    chk("rw_irq", {31'd0, irq}, 32'h0);

    // 6: reset while pin 5 is mid-count
    pin_in = 16'hFFDF;
    tick(7);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", avs_readdata, 32'h0);
    tick(2);
    reset_n = 1'b1;
    poll_data(5, found, d);
    chk("requal_lat", 32'(found), 32'd11);
    chk("requal_data", d, 32'h20);
    do_read(2'd1, d); chk("requal_edge", d, 32'h20);
    do_read(2'd2, d); chk("requal_mask", d, 32'h0);
    do_write(2'd1, 32'hFFFF_FFFF);
    tick(20);
    do_read(2'd1, d); chk("single_edge", d, 32'h0);
    do_read(2'd0, d); chk("held_data", d, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
